// File: rtl/i2c_master_controller.sv
// Single-master I2C controller: one START / address / one data byte / STOP
// transaction per accepted command, SCL derived from the system clock.
module i2c_master_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [6:0] i_cmd_addr,
  input  logic       i_cmd_rw,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  output logic [7:0] o_rdata,
  output logic       o_scl,
  inout  wire        io_sda
);

  if (CLK_DIV < 2) begin : g_clk_div_chk
    $error("i2c_master_controller: CLK_DIV must be >= 2");
  end

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
    S_WDATA_ACK, S_RDATA, S_RDATA_NACK, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   q_cnt;
  logic [1:0]      qtr;
  logic [2:0]      bit_cnt;
  logic            ack_smp;
  logic            nack_q;
  logic [7:0]      addr_byte;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_sh;
  logic            scl;
  logic            sda_low;

  logic phase_end, slot_end, smp_pt, last_bit, cmd_accept, sda_smp, scl_hi;

  assign phase_end  = (q_cnt == Q_LAST) && (state_q != S_IDLE);
  assign slot_end   = phase_end && (qtr == 2'd3);
  assign smp_pt     = phase_end && (qtr == 2'd1);
  assign last_bit   = (bit_cnt == 3'd0);
  assign cmd_accept = i_cmd_valid && (state_q == S_IDLE);
  assign scl_hi     = qtr[0] ^ qtr[1];
  // Anything but a solid 0 reads as 1: the bus idles high through its pull-up.
  assign sda_smp    = (io_sda === 1'b0) ? 1'b0 : 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      q_cnt   <= '0;
      qtr     <= 2'd0;
      bit_cnt <= 3'd0;
      ack_smp <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == S_IDLE) begin
        q_cnt <= '0;
        qtr   <= 2'd0;
      end else if (phase_end) begin
        q_cnt <= '0;
        qtr   <= qtr + 2'd1;
      end else begin
        q_cnt <= q_cnt + QW'(1);
      end
      if (state_d != state_q) begin
        bit_cnt <= (state_d == S_ADDR || state_d == S_WDATA || state_d == S_RDATA) ? 3'd7 : 3'd0;
      end else if (slot_end) begin
        bit_cnt <= bit_cnt - 3'd1;
      end
      if (smp_pt) ack_smp <= sda_smp;
      if (cmd_accept) begin
        nack_q <= 1'b0;
      end else if ((state_q == S_ADDR_ACK || state_q == S_WDATA_ACK) && slot_end) begin
        nack_q <= ack_smp;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (i_cmd_valid) state_d = S_START;
      S_START:      if (phase_end && qtr == 2'd1) state_d = S_ADDR;
      S_ADDR:       if (slot_end && last_bit) state_d = S_ADDR_ACK;
      S_ADDR_ACK:   if (slot_end) state_d = ack_smp ? S_STOP : (addr_byte[0] ? S_RDATA : S_WDATA);
      S_WDATA:      if (slot_end && last_bit) state_d = S_WDATA_ACK;
      S_WDATA_ACK:  if (slot_end) state_d = S_STOP;
      S_RDATA:      if (slot_end && last_bit) state_d = S_RDATA_NACK;
      S_RDATA_NACK: if (slot_end) state_d = S_STOP;
      S_STOP:       if (phase_end && qtr == 2'd2) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      S_START: sda_low = (qtr == 2'd1);
      S_ADDR: begin
        scl     = scl_hi;
        sda_low = ~addr_byte[bit_cnt];
      end
      S_WDATA: begin
        scl     = scl_hi;
        sda_low = ~wdata_q[bit_cnt];
      end
      S_ADDR_ACK, S_WDATA_ACK, S_RDATA, S_RDATA_NACK: scl = scl_hi;
      S_STOP: begin
        scl     = (qtr != 2'd0);
        sda_low = (qtr != 2'd2);
      end
      default: ;
    endcase
  end

  assign o_scl       = scl;
  assign io_sda      = sda_low ? 1'b0 : 1'bz;
  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);

  // Completion status is registered on the STOP -> IDLE edge and held until the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_done  <= 1'b0;
      o_nack  <= 1'b0;
      o_rdata <= 8'h00;
    end else begin
      o_done <= (state_q == S_STOP) && (state_d == S_IDLE);
      if ((state_q == S_STOP) && (state_d == S_IDLE)) begin
        o_nack <= nack_q;
        if (addr_byte[0] && !nack_q) o_rdata <= rdata_sh;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (cmd_accept) begin
      addr_byte <= {i_cmd_addr, i_cmd_rw};
      wdata_q   <= i_cmd_wdata;
    end
    if (state_q == S_RDATA && smp_pt) rdata_sh <= {rdata_sh[6:0], sda_smp};
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench for i2c_master_controller: two instances (CLK_DIV 4 and 2)
// share one behavioural slave at address 0x66 that is muxed onto either bus.
module tb_i2c_master_controller;

  localparam logic [6:0] SLV_ADDR = 7'b1100110;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n = 1'b0;
  logic       v1 = 1'b0, rw1 = 1'b0, v2 = 1'b0, rw2 = 1'b0;
  logic [6:0] a1 = '0, a2 = '0;
  logic [7:0] w1 = '0, w2 = '0;
  logic       rdy1, busy1, done1, nack1, scl1;
  logic       rdy2, busy2, done2, nack2, scl2;
  logic [7:0] rd1, rd2;
  wire        sda1, sda2;

  pullup (sda1);
  pullup (sda2);

  i2c_master_controller #(.CLK_DIV(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(v1), .o_cmd_ready(rdy1),
    .i_cmd_addr(a1), .i_cmd_rw(rw1), .i_cmd_wdata(w1), .o_busy(busy1),
    .o_done(done1), .o_nack(nack1), .o_rdata(rd1), .o_scl(scl1), .io_sda(sda1));

  i2c_master_controller #(.CLK_DIV(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(v2), .o_cmd_ready(rdy2),
    .i_cmd_addr(a2), .i_cmd_rw(rw2), .i_cmd_wdata(w2), .o_busy(busy2),
    .o_done(done2), .o_nack(nack2), .o_rdata(rd2), .o_scl(scl2), .io_sda(sda2));

  // Slave + bus monitor, sampled on the falling system-clock edge.
  logic       bus_sel = 1'b0;
  logic       sl_low = 1'b0, sl_sel = 1'b0, sl_rd = 1'b0, sl_ackbit = 1'b1;
  logic [7:0] sl_sh = '0;
  logic [7:0] sl_tx = 8'h3C;
  int         sl_bit = 0, sl_byte = 0, n_start = 0, n_stop = 0;
  logic [7:0] mon_q[$];
  logic       m_scl, m_sda, p_scl = 1'b1, p_sda = 1'b1;

  assign sda1 = (sl_low && !bus_sel) ? 1'b0 : 1'bz;
  assign sda2 = (sl_low &&  bus_sel) ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    m_scl = bus_sel ? scl2 : scl1;
    m_sda = bus_sel ? sda2 : sda1;
    if (p_scl && m_scl && p_sda && !m_sda) begin
      n_start++; sl_bit = 0; sl_byte = 0; sl_sel = 1'b0; sl_rd = 1'b0; sl_low = 1'b0;
    end else if (p_scl && m_scl && !p_sda && m_sda) begin
      n_stop++; sl_bit = 0; sl_low = 1'b0;
    end else if (!p_scl && m_scl) begin
      if (sl_bit < 8) sl_sh = {sl_sh[6:0], m_sda};
      else if (sl_bit == 8) sl_ackbit = m_sda;
      sl_bit++;
    end else if (p_scl && !m_scl) begin
      if (sl_bit == 8) begin
        mon_q.push_back(sl_sh);
        if (sl_byte == 0) begin
          sl_sel = (sl_sh[7:1] == SLV_ADDR);
          sl_rd  = sl_sh[0];
          sl_low = (sl_sh[7:1] == SLV_ADDR);
        end else begin
          sl_low = sl_sel && !sl_rd;
        end
      end else if (sl_bit == 9) begin
        sl_bit = 0;
        sl_byte++;
        sl_low = sl_sel && sl_rd && (sl_byte == 1) && !sl_tx[7];
      end else if (sl_sel && sl_rd && sl_byte == 1 && sl_bit >= 1 && sl_bit <= 7) begin
        sl_low = !sl_tx[7 - sl_bit];
      end
    end
    p_scl = m_scl;
    p_sda = m_sda;
  end

  // SCL phase lengths of the CLK_DIV=2 instance, only for phases inside a transaction.
  int   hi_cnt = 0, hi_min = 1000, hi_max = 0, lo_max = 0, run_len = 0;
  logic run_ok = 1'b0, p_scl2 = 1'b1;
  always @(negedge clk) begin
    if (scl2 != p_scl2) begin
      if (run_ok && busy2) begin
        if (p_scl2) begin
          hi_cnt++;
          if (run_len < hi_min) hi_min = run_len;
          if (run_len > hi_max) hi_max = run_len;
        end else if (run_len > lo_max) begin
          lo_max = run_len;
        end
      end
      run_ok  = busy2;
      run_len = 1;
    end else begin
      run_len++;
    end
    if (!busy2) run_ok = 1'b0;
    p_scl2 = scl2;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the done cycle number counted with the accept cycle as 0, or -1 on timeout.
  task automatic wait_done1(input int acc, output int dc);
    dc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done1) begin
        dc = cyc - acc + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic cmd1(input logic [6:0] a, input logic rw, input logic [7:0] w, output int dc);
    int acc;
    a1 = a; rw1 = rw; w1 = w; v1 = 1'b1;
    @(negedge clk);
    acc = cyc;
    v1 = 1'b0;
    chk("busy_after_accept", busy1, 1'b1);
    chk("ready_while_busy", rdy1, 1'b0);
    wait_done1(acc, dc);
  endtask

  int dc, acc, d1;
  int s0, t0;

  initial begin
    #1;
    chk("rst_scl", scl1, 1'b1);
    chk("rst_sda", sda1, 1'b1);
    chk("rst_ready", rdy1, 1'b1);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_nack", nack1, 1'b0);
    chk("rst_rdata", rd1, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write 0x66 / 0xA5 to the slave
    mon_q.delete();
    cmd1(7'h66, 1'b0, 8'hA5, dc);
    chk("t1_done_cycle", dc, 309);
    chk("t1_nack", nack1, 1'b0);
    chk("t1_rdata_kept", rd1, 8'h00);
    chk("t1_nbytes", mon_q.size(), 2);
    chk("t1_addr_byte", mon_q[0], 8'hCC);
    chk("t1_data_byte", mon_q[1], 8'hA5);
    chk("t1_data_ack", sl_ackbit, 1'b0);
    @(negedge clk);
    chk("t1_done_pulse", done1, 1'b0);
    chk("t1_nack_hold", nack1, 1'b0);

    // 2: write to an absent address
    repeat (5) @(negedge clk);
    mon_q.delete();
    cmd1(7'h12, 1'b0, 8'h77, dc);
    chk("t2_done_cycle", dc, 165);
    chk("t2_nack", nack1, 1'b1);
    chk("t2_nbytes", mon_q.size(), 1);
    chk("t2_addr_byte", mon_q[0], 8'h24);
    chk("t2_rdata_kept", rd1, 8'h00);

    // 3: read 0x66, slave returns 0x3C
    repeat (5) @(negedge clk);
    mon_q.delete();
    cmd1(7'h66, 1'b1, 8'h00, dc);
    chk("t3_done_cycle", dc, 309);
    chk("t3_rdata", rd1, 8'h3C);
    chk("t3_nack", nack1, 1'b0);
    chk("t3_master_nack_bit", sl_ackbit, 1'b1);
    chk("t3_addr_byte", mon_q[0], 8'hCD);
    chk("t3_data_byte", mon_q[1], 8'h3C);

    // 4: valid held high across two writes
    repeat (5) @(negedge clk);
    mon_q.delete();
    s0 = n_start; t0 = n_stop;
    a1 = 7'h66; rw1 = 1'b0; w1 = 8'h11; v1 = 1'b1;
    @(negedge clk);
    acc = cyc;
    w1 = 8'hFF;
    repeat (50) @(negedge clk);
    chk("t4_ready_low", rdy1, 1'b0);
    chk("t4_busy_high", busy1, 1'b1);
    wait_done1(acc, dc);
    chk("t4_done1_cycle", dc, 309);
    chk("t4_ready_in_done", rdy1, 1'b1);
    d1 = cyc;
    w1 = 8'h22;
    @(negedge clk);
    v1 = 1'b0;
    chk("t4_second_accepted", busy1, 1'b1);
    wait_done1(d1, dc);
    chk("t4_done2_cycle", dc, 310);
    chk("t4_nack", nack1, 1'b0);
    chk("t4_rdata_kept", rd1, 8'h3C);
    chk("t4_nbytes", mon_q.size(), 4);
    chk("t4_byte1", mon_q[1], 8'h11);
    chk("t4_byte3", mon_q[3], 8'h22);
    chk("t4_starts", n_start - s0, 2);
    chk("t4_stops", n_stop - t0, 2);

    // 5: reset in the middle of the data byte
    repeat (5) @(negedge clk);
    a1 = 7'h66; rw1 = 1'b0; w1 = 8'h5A; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_scl", scl1, 1'b1);
    chk("t5_sda", sda1, 1'b1);
    chk("t5_ready", rdy1, 1'b1);
    chk("t5_busy", busy1, 1'b0);
    chk("t5_rdata", rd1, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_q.delete();
    cmd1(7'h66, 1'b0, 8'hA5, dc);
    chk("t5_done_cycle", dc, 309);
    chk("t5_nack", nack1, 1'b0);
    chk("t5_data_byte", mon_q[1], 8'hA5);

    // 6: CLK_DIV=2 instance
    repeat (5) @(negedge clk);
    bus_sel = 1'b1;
    repeat (2) @(negedge clk);
    mon_q.delete();
    a2 = 7'h66; rw2 = 1'b0; w2 = 8'h5A; v2 = 1'b1;
    @(negedge clk);
    acc = cyc;
    v2 = 1'b0;
    dc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (done2) begin
        dc = cyc - acc + 1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_done_cycle", dc, 155);
    chk("t6_nack", nack2, 1'b0);
    chk("t6_data_byte", mon_q[1], 8'h5A);
    chk("t6_hi_count", hi_cnt, 18);
    chk("t6_hi_min", hi_min, 4);
    chk("t6_hi_max", hi_max, 4);
    chk("t6_lo_max", lo_max, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
